// File: rtl/spi_slave_uc_pkg.sv
// rtl/spi_slave_uc_pkg.sv - shared types and constants for the UC-link SPI slave
package spi_slave_pkg;

  // Frame length used when the instantiating design does not override it
  localparam int DEFAULT_WIDTH = 16;

  // Synchronizer power-on levels match the idle state of each pin
  localparam logic SCK_RST_VAL  = 1'b0;
  localparam logic CS_RST_VAL   = 1'b1;
  localparam logic MOSI_RST_VAL = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/spi_slave_uc_if.sv
// rtl/spi_slave_uc_if.sv - SPI pins plus parallel rx/tx port of the UC-link slave
interface spi_slave_uc_if
  import spi_slave_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             SCK;
  logic             CSbar;
  logic             MOSI;
  logic             MISO;
  logic [WIDTH-1:0] TX_DATA;
  logic             TX_LOAD;
  logic             TX_READY;
  logic             TX_UNDERRUN;
  logic [WIDTH-1:0] RX_DATA;
  logic             RX_VALID;
  logic             FRAME_ERR;
  logic             BUSY;

  // Side seen by the slave block itself
  modport slave (
    input  SCK, CSbar, MOSI, TX_DATA, TX_LOAD,
    output MISO, TX_READY, TX_UNDERRUN, RX_DATA, RX_VALID, FRAME_ERR, BUSY
  );

  // Side seen by the SPI master and the local command logic
  modport master (
    output SCK, CSbar, MOSI, TX_DATA, TX_LOAD,
    input  MISO, TX_READY, TX_UNDERRUN, RX_DATA, RX_VALID, FRAME_ERR, BUSY
  );

endinterface

// File: rtl/spi_slave_uc_sync_edge.sv
// rtl/spi_slave_uc_sync_edge.sv - multi-flop pin synchronizer with rise/fall pulses
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the raw pin into the chain; prev holds last cycle's synchronized level
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Chain and edge flop reset to the pin's idle level so reset creates no edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave_uc.sv
// rtl/spi_slave_uc.sv - SPI mode-0 slave with oversampled pins, rx strobe and double-buffered reply
module spi_slave_uc
  import spi_slave_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic          SYS_CLK,
  input  logic          RST,
  spi_slave_uc_if.slave bus
);

  localparam int              CW         = $clog2(WIDTH + 1);
  localparam int              FW         = $clog2(SYNC_STAGES + 2);
  localparam logic [FW-1:0]   FLUSH_DONE = FW'(SYNC_STAGES + 1);
  localparam logic [CW-1:0]   LAST_BIT   = CW'(WIDTH);

  logic sck_level_unused, sck_rise, sck_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-2:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_word;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] start_word;
  logic             miso_q, miso_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             underrun_q, underrun_d;
  logic             ferr_q, ferr_d;
  logic             err_done_q, err_done_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             full_q, full_d;
  logic [FW-1:0]    flush_q, flush_d;
  logic             armed_q, armed_d;
  logic             frame_start;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_RST_VAL)) u_sync_sck (
    .clk (SYS_CLK), .rst (RST), .d (bus.SCK),
    .q (sck_level_unused), .rise (sck_rise), .fall (sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CS_RST_VAL)) u_sync_cs (
    .clk (SYS_CLK), .rst (RST), .d (bus.CSbar),
    .q (cs_level), .rise (cs_rise), .fall (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_RST_VAL)) u_sync_mosi (
    .clk (SYS_CLK), .rst (RST), .d (bus.MOSI),
    .q (mosi_s), .rise (mosi_rise_unused), .fall (mosi_fall_unused)
  );

  assign cnt_inc     = cnt_q + CW'(1);
  assign rx_word     = {rx_sh_q, mosi_s};
  assign start_word  = full_q ? shadow_q : '0;
  assign frame_start = (state_q == ST_IDLE) && cs_fall && armed_q;

  // Arm frame detection only once the CS synchronizer holds real pin data and shows
  // the pin high, so a select already low at reset release never starts a frame
  always_comb begin
    flush_d = (flush_q == FLUSH_DONE) ? flush_q : flush_q + FW'(1);
    armed_d = armed_q | ((flush_q == FLUSH_DONE) & cs_level);
  end

  // Reply shadow: a load in the frame-start cycle refills the slot being emptied
  always_comb begin
    shadow_d = shadow_q;
    full_d   = full_q;
    if (frame_start) begin
      full_d = 1'b0;
    end
    if (bus.TX_LOAD && (!full_q || frame_start)) begin
      shadow_d = bus.TX_DATA;
      full_d   = 1'b1;
    end
  end

  // Frame FSM: shift on synchronized SCK edges, strobe the word, police the tail
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    miso_d     = miso_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    ferr_d     = 1'b0;
    err_done_d = err_done_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d    = ST_SHIFT;
          cnt_d      = '0;
          miso_d     = start_word[WIDTH-1];
          tx_sh_d    = {start_word[WIDTH-2:0], 1'b0};
          underrun_d = ~full_q;
          err_done_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          // Partial word is dropped; rx_sh is overwritten by the next frame anyway
          ferr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (sck_rise) begin
            rx_sh_d = rx_word[WIDTH-2:0];
            cnt_d   = cnt_inc;
            if (cnt_inc == LAST_BIT) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
              state_d    = ST_HOLD;
            end
          end
          if (sck_fall) begin
            miso_d  = tx_sh_q[WIDTH-1];
            tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sck_rise && !err_done_q) begin
          ferr_d     = 1'b1;
          err_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, all returned to idle values by RST
  always_ff @(posedge SYS_CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      miso_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      ferr_q     <= 1'b0;
      err_done_q <= 1'b0;
      shadow_q   <= '0;
      full_q     <= 1'b0;
      flush_q    <= '0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      miso_q     <= miso_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      ferr_q     <= ferr_d;
      err_done_q <= err_done_d;
      shadow_q   <= shadow_d;
      full_q     <= full_d;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.TX_READY    = ~full_q;
  assign bus.TX_UNDERRUN = underrun_q;
  assign bus.RX_DATA     = rx_data_q;
  assign bus.RX_VALID    = rx_valid_q;
  assign bus.FRAME_ERR   = ferr_q;
  assign bus.BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_uc.sv
// tb/tb_spi_slave_uc.sv - self-checking bench for the UC-link SPI slave
module tb_spi_slave_uc;

  localparam int HALF = 10;
  localparam int LEAD = 12;

  typedef struct {
    logic        do_load;
    logic [15:0] load_w;
    logic [15:0] mosi_w;
    int          nbits;
    logic [15:0] exp_miso;
    int          exp_rxv;
    int          exp_und;
    int          exp_ferr;
    logic [15:0] exp_rx;
  } vec_t;

  logic clk;
  logic rst;

  int errors;
  int checks;
  int rxv_cnt;
  int und_cnt;
  int ferr_cnt;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  vec_t vecs[5];

  spi_slave_uc_if #(.WIDTH(16)) ifc ();

  spi_slave_uc #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .SYS_CLK (clk),
    .RST     (rst),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rxv_cnt  = 0;
    und_cnt  = 0;
    ferr_cnt = 0;
  end

  always @(negedge clk) begin
    if (ifc.RX_VALID) begin
      rxv_cnt++;
      got_q.push_back(ifc.RX_DATA);
    end
    if (ifc.TX_UNDERRUN) und_cnt++;
    if (ifc.FRAME_ERR) ferr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000ns");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_word(input logic [15:0] w);
    ifc.TX_DATA = w;
    ifc.TX_LOAD = 1'b1;
    tick(1);
    ifc.TX_LOAD = 1'b0;
  endtask

  // CSbar falls; optionally TX_LOAD is held in the cycle the slave detects it
  task automatic cs_begin(input logic load_at_start, input logic [15:0] w);
    ifc.CSbar = 1'b0;
    tick(2);
    if (load_at_start) begin
      ifc.TX_DATA = w;
      ifc.TX_LOAD = 1'b1;
    end
    tick(1);
    ifc.TX_LOAD = 1'b0;
    tick(LEAD - 3);
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n, output logic [15:0] cap);
    logic m;
    cap = '0;
    for (int i = 0; i < n; i++) begin
      if (i < 16) ifc.MOSI = w[15-i];
      else        ifc.MOSI = 1'b0;
      tick(HALF);
      ifc.SCK = 1'b1;
      m = ifc.MISO;
      if (i < 16) cap[15-i] = m;
      tick(HALF);
      ifc.SCK = 1'b0;
    end
  endtask

  task automatic cs_end();
    tick(HALF);
    ifc.CSbar = 1'b1;
    tick(LEAD);
  endtask

  task automatic compare_sb(input string nm);
    logic [15:0] e;
    logic [15:0] g;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() == 0) begin
        chk({nm, "_unexpected_rx"}, {16'h0, g}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk({nm, "_sb_rx_data"}, g, e);
      end
    end
    chk({nm, "_sb_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] cap;
    int r0, u0, f0;
    errors = 0;
    checks = 0;

    vecs[0] = '{1'b1, 16'hA55A, 16'h1234, 16, 16'hA55A, 1, 0, 0, 16'h1234};
    vecs[1] = '{1'b0, 16'h0000, 16'hFFFF, 16, 16'h0000, 1, 1, 0, 16'hFFFF};
    vecs[2] = '{1'b0, 16'h0000, 16'h5A5A,  9, 16'h0000, 0, 1, 1, 16'hFFFF};
    vecs[3] = '{1'b1, 16'h0F0F, 16'hBEEF, 18, 16'h0F0F, 1, 0, 1, 16'hBEEF};
    vecs[4] = '{1'b1, 16'hC3E1, 16'h0001, 16, 16'hC3E1, 1, 0, 0, 16'h0001};

    rst         = 1'b1;
    ifc.SCK     = 1'b0;
    ifc.CSbar   = 1'b1;
    ifc.MOSI    = 1'b0;
    ifc.TX_DATA = '0;
    ifc.TX_LOAD = 1'b0;
    tick(3);
    chk("rst_miso",      ifc.MISO,        0);
    chk("rst_rx_data",   ifc.RX_DATA,     0);
    chk("rst_rx_valid",  ifc.RX_VALID,    0);
    chk("rst_tx_ready",  ifc.TX_READY,    1);
    chk("rst_underrun",  ifc.TX_UNDERRUN, 0);
    chk("rst_frame_err", ifc.FRAME_ERR,   0);
    chk("rst_busy",      ifc.BUSY,        0);
    rst = 1'b0;
    tick(8);

    for (int k = 0; k < 5; k++) begin
      if (vecs[k].do_load) begin
        load_word(vecs[k].load_w);
        chk($sformatf("v%0d_ready_after_load", k), ifc.TX_READY, 0);
      end
      r0 = rxv_cnt;
      u0 = und_cnt;
      f0 = ferr_cnt;
      if (vecs[k].exp_rxv == 1) exp_q.push_back(vecs[k].exp_rx);
      cs_begin(1'b0, 16'h0000);
      chk($sformatf("v%0d_busy_mid", k), ifc.BUSY, 1);
      chk($sformatf("v%0d_ready_mid", k), ifc.TX_READY, 1);
      shift_bits(vecs[k].mosi_w, vecs[k].nbits, cap);
      cs_end();
      chk($sformatf("v%0d_rx_valid_cnt", k), rxv_cnt - r0, vecs[k].exp_rxv);
      chk($sformatf("v%0d_underrun_cnt", k), und_cnt - u0, vecs[k].exp_und);
      chk($sformatf("v%0d_frame_err_cnt", k), ferr_cnt - f0, vecs[k].exp_ferr);
      if (vecs[k].nbits >= 16) chk($sformatf("v%0d_miso_word", k), cap, vecs[k].exp_miso);
      chk($sformatf("v%0d_rx_data", k), ifc.RX_DATA, vecs[k].exp_rx);
      chk($sformatf("v%0d_busy_after", k), ifc.BUSY, 0);
      compare_sb($sformatf("v%0d", k));
    end

    // TX_LOAD coincident with frame start, then a load against a full shadow
    load_word(16'h8000);
    u0 = und_cnt;
    exp_q.push_back(16'h2222);
    cs_begin(1'b1, 16'h0001);
    chk("startload_ready", ifc.TX_READY, 0);
    load_word(16'h7777);
    chk("dropload_ready", ifc.TX_READY, 0);
    shift_bits(16'h2222, 16, cap);
    cs_end();
    chk("startload_frame1_miso", cap, 16'h8000);
    exp_q.push_back(16'h3333);
    cs_begin(1'b0, 16'h0000);
    chk("startload_frame2_ready", ifc.TX_READY, 1);
    shift_bits(16'h3333, 16, cap);
    cs_end();
    chk("startload_frame2_miso", cap, 16'h0001);
    chk("startload_underrun_cnt", und_cnt - u0, 0);
    compare_sb("startload");

    // Asynchronous reset in the middle of a frame with CSbar held low
    load_word(16'h1111);
    r0 = rxv_cnt;
    f0 = ferr_cnt;
    cs_begin(1'b0, 16'h0000);
    shift_bits(16'hAB00, 8, cap);
    rst = 1'b1;
    #1;
    chk("midrst_busy", ifc.BUSY, 0);
    chk("midrst_ready", ifc.TX_READY, 1);
    tick(2);
    rst = 1'b0;
    shift_bits(16'hCD00, 8, cap);
    cs_end();
    chk("midrst_rx_valid_cnt", rxv_cnt - r0, 0);
    chk("midrst_frame_err_cnt", ferr_cnt - f0, 0);
    chk("midrst_rx_data", ifc.RX_DATA, 0);
    r0 = rxv_cnt;
    u0 = und_cnt;
    exp_q.push_back(16'h600D);
    cs_begin(1'b0, 16'h0000);
    shift_bits(16'h600D, 16, cap);
    cs_end();
    chk("postrst_rx_valid_cnt", rxv_cnt - r0, 1);
    chk("postrst_underrun_cnt", und_cnt - u0, 1);
    chk("postrst_miso", cap, 16'h0000);
    chk("postrst_rx_data", ifc.RX_DATA, 16'h600D);
    compare_sb("postrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
